trap_csr_state: RTL and testbench
=================================

Name: trap_csr_state

Overview:
- Holds the privileged trap state: privilege level, mstatus enable/stack bits, mepc/sepc, mcause/scause, tvecs, delegation, mie/mip.
- Sits directly downstream of the trap handler. It consumes the handler's trap-info update and xret retire events.
- Feeds the handler's TrapControlState fields back: priv, mtvec, stvec, retvec, medeleg, mideleg, and interrupt pending/cause/delegate.
- Also serves CSR reads and writes from the CSR execution unit.

Parameters:
- RESET_MTVEC, 30'h0, mtvec base (word address) after reset.
- HART_ID, 0, value returned by mhartid (0xF14).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset (active when 0)
- IN_trapValid  in  1  trap taken this cycle
- IN_trapPC  in  32  faulting or return PC; bit 0 is ignored
- IN_trapCause  in  4  exception or interrupt code
- IN_trapDelegate  in  1  1 = trap to S-mode
- IN_trapIsInterrupt  in  1  interrupt flag
- IN_xretValid  in  1  mret/sret retired
- IN_xretIsMret  in  1  1 = mret, 0 = sret
- IN_retvecSelM  in  1  selects the OUT_retvec source (1 = mepc)
- IN_irq  in  3  {MEIP, MTIP, MSIP} level inputs
- IN_csrRe  in  1  CSR read request
- IN_csrWe  in  1  CSR write request
- IN_csrAddr  in  12  CSR address
- IN_csrWData  in  32  CSR write data
- OUT_csrRData  out  32  read data
- OUT_csrRValid  out  1  read data valid
- OUT_priv  out  2  current privilege (3 = M, 1 = S, 0 = U)
- OUT_mtvec  out  30  mtvec base
- OUT_stvec  out  30  stvec base
- OUT_retvec  out  31  IN_retvecSelM ? mepc : sepc (combinational)
- OUT_medeleg  out  16
- OUT_mideleg  out  16
- OUT_interruptPending  out  1
- OUT_interruptCause  out  4
- OUT_interruptDelegate  out  1

Behaviour:
- Reset (rst==0 at posedge):
  - priv=M; mtvec=RESET_MTVEC; every other state register 0.
  - All outputs 0 except OUT_priv=3 and OUT_mtvec=RESET_MTVEC.
- Update order within one cycle, computed combinationally into next-state:
  1. xret, if valid.
  2. Trap, if valid, using the post-xret priv/MIE/SIE.
  3. CSR write, only if neither xret nor trap is valid; otherwise the write is discarded.
- mret: priv<=MPP; MIE<=MPIE; MPIE<=1; MPP<=U.
- sret: priv<={1'b0,SPP}; SIE<=SPIE; SPIE<=1; SPP<=0. An sret in U-mode is never presented.
- Trap with delegate=0:
  - mepc<=trapPC[31:1]; mcause<={isInt,27'b0,cause}.
  - MPIE<=MIE; MIE<=0; MPP<=priv; priv<=M.
- Trap with delegate=1:
  - sepc, scause, SPIE<=SIE, SIE<=0, SPP<=priv[0], priv<=S.
- CSR map:
  - mstatus 0x300: writable bits 1, 3, 5, 7, 8, 12:11. MPP write of 2 is stored as 0.
  - sstatus 0x100: view of bits 1, 5, 8 only.
  - medeleg 0x302, mideleg 0x303: low 16 bits.
  - mie 0x304: low 16 bits.
  - mtvec 0x305, stvec 0x105: bits 31:2 stored; mode bits read 0.
  - mepc 0x341, sepc 0x141: bit 0 reads 0.
  - mcause 0x342, scause 0x142.
  - mip 0x344: bits 11/7/3 mirror IN_irq and are read-only; bits 9/5/1 are writable.
  - mhartid 0xF14: read-only.
  - Unknown address: reads 0, write ignored.
- Reads: OUT_csrRData/OUT_csrRValid are registered, 1 cycle after IN_csrRe. Data is the pre-update state of the request cycle, so a same-cycle write is not forwarded.
- Interrupts, recomputed every cycle from current registered state, outputs registered (1-cycle latency):
  - p = mip & mie.
  - A non-delegated bit is enabled when priv<M or MIE=1.
  - A delegated bit (mideleg=1) is enabled when priv==U, or priv==S && SIE=1. It is never enabled in M.
  - Priority among enabled bits: 11 > 3 > 7 > 9 > 1 > 5.
  - OUT_interruptDelegate = mideleg[cause] && priv!=M.
  - When none is enabled: pending=0, cause=0, delegate=0.
- IN_irq is used unsynchronised; the upstream synchroniser is owned elsewhere.

Optional Feature:
- Macro: CSR_TVAL_EN.
- When defined:
  - Adds port IN_trapTval (in, 32).
  - Adds registers mtval 0x343 and stval 0x143, written on the corresponding trap and writable by CSR.
- When undefined: the port is absent; 0x343/0x143 read 0 and writes are ignored.

Test Plan:
- Reset: after reset, OUT_priv=3, OUT_mtvec=RESET_MTVEC, OUT_interruptPending=0, and a read of 0x300 returns 0.
- M-trap: priv=U, trapValid with PC=0x80001234, cause=2, delegate=0 -> next cycle mepc reads 0x80001234, mcause=2, priv=3, MPP=0, MIE=0.
- Delegated ecall: priv=U, cause=8, delegate=1 -> sepc set, scause=8, priv=1, SPP=0. A following sret -> priv=0, SIE=SPIE.
- Interrupt priority: MIE=1, mie=0x888, IN_irq=3'b111 -> pending=1, cause=11. Drop MEIP -> cause=3.
- mret and interrupt in the same cycle:
  - Setup: MPP=U, MPIE=1, and the trap carries isInterrupt=1, cause=7.
  - Required: mepc=trapPC, MPP=0 (post-xret priv), MPIE=1, MIE=0, priv=3.
- Write collision: IN_csrWe to mtvec with IN_trapValid in the same cycle -> mtvec unchanged. The same write alone updates mtvec 1 cycle later.

Source files
------------

// File: rtl/trap_csr_state.sv
// rtl/trap_csr_state.sv - privileged trap/CSR state (priv, mstatus, epc/cause/tvec, deleg, mie/mip); optional mtval/stval under CSR_TVAL_EN
module trap_csr_state #(
  parameter logic [29:0] RESET_MTVEC = 30'h0,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_trapValid,
  input  logic [31:0] IN_trapPC,
  input  logic [3:0]  IN_trapCause,
  input  logic        IN_trapDelegate,
  input  logic        IN_trapIsInterrupt,
`ifdef CSR_TVAL_EN
  input  logic [31:0] IN_trapTval,
`endif
  input  logic        IN_xretValid,
  input  logic        IN_xretIsMret,
  input  logic        IN_retvecSelM,
  input  logic [2:0]  IN_irq,
  input  logic        IN_csrRe,
  input  logic        IN_csrWe,
  input  logic [11:0] IN_csrAddr,
  input  logic [31:0] IN_csrWData,
  output logic [31:0] OUT_csrRData,
  output logic        OUT_csrRValid,
  output logic [1:0]  OUT_priv,
  output logic [29:0] OUT_mtvec,
  output logic [29:0] OUT_stvec,
  output logic [30:0] OUT_retvec,
  output logic [15:0] OUT_medeleg,
  output logic [15:0] OUT_mideleg,
  output logic        OUT_interruptPending,
  output logic [3:0]  OUT_interruptCause,
  output logic        OUT_interruptDelegate
);

  typedef struct packed {
    logic [1:0]  priv;
    logic        sie;
    logic        mie;
    logic        spie;
    logic        mpie;
    logic        spp;
    logic [1:0]  mpp;
    logic [29:0] mtvec;
    logic [29:0] stvec;
    logic [30:0] mepc;
    logic [30:0] sepc;
    logic [31:0] mcause;
    logic [31:0] scause;
    logic [15:0] medeleg;
    logic [15:0] mideleg;
    logic [15:0] mie_en;
    logic [15:0] mip_sw;
`ifdef CSR_TVAL_EN
    logic [31:0] mtval;
    logic [31:0] stval;
`endif
  } state_t;

  localparam logic [15:0] MIP_SW_MASK = 16'h0222;

  state_t state_q, state_d;
  logic [31:0] mstatus_rd, rd_mux, rdata_q;
  logic [15:0] mip_val, pend, enabled;
  logic        rvalid_q, m_en, s_en, any_en, irq_pending_q, irq_deleg_q;
  logic [3:0]  cause_sel, irq_cause_q;
  logic        unused_bits;

  // PC bit 0 is architecturally ignored
  assign unused_bits = IN_trapPC[0];

  assign mstatus_rd = {19'b0, state_q.mpp, 2'b0, state_q.spp, state_q.mpie, 1'b0,
                       state_q.spie, 1'b0, state_q.mie, 1'b0, state_q.sie, 1'b0};
  assign mip_val = (state_q.mip_sw & MIP_SW_MASK) |
                   {4'b0, IN_irq[2], 3'b0, IN_irq[1], 3'b0, IN_irq[0], 3'b0};

  // Read mux over pre-update state
  always_comb begin
    rd_mux = 32'h0;
    case (IN_csrAddr)
      12'h300: rd_mux = mstatus_rd;
      12'h100: rd_mux = mstatus_rd & 32'h0000_0122;
      12'h302: rd_mux = {16'b0, state_q.medeleg};
      12'h303: rd_mux = {16'b0, state_q.mideleg};
      12'h304: rd_mux = {16'b0, state_q.mie_en};
      12'h305: rd_mux = {state_q.mtvec, 2'b00};
      12'h105: rd_mux = {state_q.stvec, 2'b00};
      12'h341: rd_mux = {state_q.mepc, 1'b0};
      12'h141: rd_mux = {state_q.sepc, 1'b0};
      12'h342: rd_mux = state_q.mcause;
      12'h142: rd_mux = state_q.scause;
      12'h344: rd_mux = {16'b0, mip_val};
      12'hF14: rd_mux = HART_ID;
`ifdef CSR_TVAL_EN
      12'h343: rd_mux = state_q.mtval;
      12'h143: rd_mux = state_q.stval;
`endif
      default: rd_mux = 32'h0;
    endcase
  end

  // Next state: xret first, then trap on post-xret state, then CSR write if neither fired
  always_comb begin
    state_d = state_q;
    if (IN_xretValid) begin
      if (IN_xretIsMret) begin
        state_d.priv = state_d.mpp;
        state_d.mie  = state_d.mpie;
        state_d.mpie = 1'b1;
        state_d.mpp  = 2'd0;
      end else begin
        state_d.priv = {1'b0, state_d.spp};
        state_d.sie  = state_d.spie;
        state_d.spie = 1'b1;
        state_d.spp  = 1'b0;
      end
    end
    if (IN_trapValid) begin
      if (!IN_trapDelegate) begin
        state_d.mepc   = IN_trapPC[31:1];
        state_d.mcause = {IN_trapIsInterrupt, 27'b0, IN_trapCause};
        state_d.mpie   = state_d.mie;
        state_d.mie    = 1'b0;
        state_d.mpp    = state_d.priv;
        state_d.priv   = 2'd3;
`ifdef CSR_TVAL_EN
        state_d.mtval  = IN_trapTval;
`endif
      end else begin
        state_d.sepc   = IN_trapPC[31:1];
        state_d.scause = {IN_trapIsInterrupt, 27'b0, IN_trapCause};
        state_d.spie   = state_d.sie;
        state_d.sie    = 1'b0;
        state_d.spp    = state_d.priv[0];
        state_d.priv   = 2'd1;
`ifdef CSR_TVAL_EN
        state_d.stval  = IN_trapTval;
`endif
      end
    end
    if (IN_csrWe && !IN_xretValid && !IN_trapValid) begin
      case (IN_csrAddr)
        12'h300: begin
          state_d.sie  = IN_csrWData[1];
          state_d.mie  = IN_csrWData[3];
          state_d.spie = IN_csrWData[5];
          state_d.mpie = IN_csrWData[7];
          state_d.spp  = IN_csrWData[8];
          state_d.mpp  = (IN_csrWData[12:11] == 2'd2) ? 2'd0 : IN_csrWData[12:11];
        end
        12'h100: begin
          state_d.sie  = IN_csrWData[1];
          state_d.spie = IN_csrWData[5];
          state_d.spp  = IN_csrWData[8];
        end
        12'h302: state_d.medeleg = IN_csrWData[15:0];
        12'h303: state_d.mideleg = IN_csrWData[15:0];
        12'h304: state_d.mie_en  = IN_csrWData[15:0];
        12'h305: state_d.mtvec   = IN_csrWData[31:2];
        12'h105: state_d.stvec   = IN_csrWData[31:2];
        12'h341: state_d.mepc    = IN_csrWData[31:1];
        12'h141: state_d.sepc    = IN_csrWData[31:1];
        12'h342: state_d.mcause  = IN_csrWData;
        12'h142: state_d.scause  = IN_csrWData;
        12'h344: state_d.mip_sw  = IN_csrWData[15:0] & MIP_SW_MASK;
`ifdef CSR_TVAL_EN
        12'h343: state_d.mtval   = IN_csrWData;
        12'h143: state_d.stval   = IN_csrWData;
`endif
        default: ;
      endcase
    end
  end

  // Interrupt select: enable per delegation, fixed priority 11 > 3 > 7 > 9 > 1 > 5
  always_comb begin
    pend    = mip_val & state_q.mie_en;
    m_en    = (state_q.priv != 2'd3) || state_q.mie;
    s_en    = (state_q.priv == 2'd0) || ((state_q.priv == 2'd1) && state_q.sie);
    enabled = pend & ((~state_q.mideleg & {16{m_en}}) | (state_q.mideleg & {16{s_en}}));
    any_en  = 1'b1;
    if      (enabled[11]) cause_sel = 4'd11;
    else if (enabled[3])  cause_sel = 4'd3;
    else if (enabled[7])  cause_sel = 4'd7;
    else if (enabled[9])  cause_sel = 4'd9;
    else if (enabled[1])  cause_sel = 4'd1;
    else if (enabled[5])  cause_sel = 4'd5;
    else begin
      cause_sel = 4'd0;
      any_en    = 1'b0;
    end
  end

  // State, read-data and interrupt output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= '0;
      state_q.priv  <= 2'd3;
      state_q.mtvec <= RESET_MTVEC;
      rdata_q       <= 32'h0;
      rvalid_q      <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_cause_q   <= 4'd0;
      irq_deleg_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= IN_csrRe ? rd_mux : 32'h0;
      rvalid_q      <= IN_csrRe;
      irq_pending_q <= any_en;
      irq_cause_q   <= cause_sel;
      irq_deleg_q   <= any_en && state_q.mideleg[cause_sel] && (state_q.priv != 2'd3);
    end
  end

  assign OUT_csrRData          = rdata_q;
  assign OUT_csrRValid         = rvalid_q;
  assign OUT_priv              = state_q.priv;
  assign OUT_mtvec             = state_q.mtvec;
  assign OUT_stvec             = state_q.stvec;
  assign OUT_retvec            = IN_retvecSelM ? state_q.mepc : state_q.sepc;
  assign OUT_medeleg           = state_q.medeleg;
  assign OUT_mideleg           = state_q.mideleg;
  assign OUT_interruptPending  = irq_pending_q;
  assign OUT_interruptCause    = irq_cause_q;
  assign OUT_interruptDelegate = irq_deleg_q;

endmodule

// File: tb/tb_trap_csr_state.sv
// tb/tb_trap_csr_state.sv - scoreboard bench for trap_csr_state
module tb_trap_csr_state;
  logic        clk = 1'b0;
  logic        rst;
  logic        IN_trapValid, IN_trapDelegate, IN_trapIsInterrupt;
  logic [31:0] IN_trapPC;
  logic [3:0]  IN_trapCause;
`ifdef CSR_TVAL_EN
  logic [31:0] IN_trapTval;
`endif
  logic        IN_xretValid, IN_xretIsMret, IN_retvecSelM;
  logic [2:0]  IN_irq;
  logic        IN_csrRe, IN_csrWe;
  logic [11:0] IN_csrAddr;
  logic [31:0] IN_csrWData;
  logic [31:0] OUT_csrRData;
  logic        OUT_csrRValid;
  logic [1:0]  OUT_priv;
  logic [29:0] OUT_mtvec, OUT_stvec;
  logic [30:0] OUT_retvec;
  logic [15:0] OUT_medeleg, OUT_mideleg;
  logic        OUT_interruptPending, OUT_interruptDelegate;
  logic [3:0]  OUT_interruptCause;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  trap_csr_state #(.RESET_MTVEC(30'h100), .HART_ID(32'd5)) dut (
    .clk(clk), .rst(rst),
    .IN_trapValid(IN_trapValid), .IN_trapPC(IN_trapPC), .IN_trapCause(IN_trapCause),
    .IN_trapDelegate(IN_trapDelegate), .IN_trapIsInterrupt(IN_trapIsInterrupt),
`ifdef CSR_TVAL_EN
    .IN_trapTval(IN_trapTval),
`endif
    .IN_xretValid(IN_xretValid), .IN_xretIsMret(IN_xretIsMret), .IN_retvecSelM(IN_retvecSelM),
    .IN_irq(IN_irq), .IN_csrRe(IN_csrRe), .IN_csrWe(IN_csrWe), .IN_csrAddr(IN_csrAddr),
    .IN_csrWData(IN_csrWData), .OUT_csrRData(OUT_csrRData), .OUT_csrRValid(OUT_csrRValid),
    .OUT_priv(OUT_priv), .OUT_mtvec(OUT_mtvec), .OUT_stvec(OUT_stvec), .OUT_retvec(OUT_retvec),
    .OUT_medeleg(OUT_medeleg), .OUT_mideleg(OUT_mideleg),
    .OUT_interruptPending(OUT_interruptPending), .OUT_interruptCause(OUT_interruptCause),
    .OUT_interruptDelegate(OUT_interruptDelegate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every read response is matched against the oldest expected entry
  always @(negedge clk) begin
    if (OUT_csrRValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got data 0x%0h expected no response", OUT_csrRData);
      end else begin
        chk(name_q.pop_front(), OUT_csrRData, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
    IN_csrRe = 1'b1; IN_csrAddr = addr;
    exp_q.push_back(exp); name_q.push_back(name);
    step(1);
    IN_csrRe = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    IN_csrWe = 1'b1; IN_csrAddr = addr; IN_csrWData = data;
    step(1);
    IN_csrWe = 1'b0;
  endtask

  task automatic trap(input logic [31:0] pc, input logic [3:0] cause, input logic deleg, input logic is_int);
    IN_trapValid = 1'b1; IN_trapPC = pc; IN_trapCause = cause;
    IN_trapDelegate = deleg; IN_trapIsInterrupt = is_int;
    step(1);
    IN_trapValid = 1'b0;
  endtask

  task automatic xret(input logic is_mret);
    IN_xretValid = 1'b1; IN_xretIsMret = is_mret;
    step(1);
    IN_xretValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    IN_trapValid = 0; IN_trapPC = 0; IN_trapCause = 0; IN_trapDelegate = 0; IN_trapIsInterrupt = 0;
`ifdef CSR_TVAL_EN
    IN_trapTval = 0;
`endif
    IN_xretValid = 0; IN_xretIsMret = 0; IN_retvecSelM = 0; IN_irq = 0;
    IN_csrRe = 0; IN_csrWe = 0; IN_csrAddr = 0; IN_csrWData = 0;
    step(2);
    rst = 1'b1;

    // Reset state
    chk("rst_priv", 32'(OUT_priv), 32'd3);
    chk("rst_mtvec", 32'(OUT_mtvec), 32'h100);
    chk("rst_stvec", 32'(OUT_stvec), 32'h0);
    chk("rst_pending", 32'(OUT_interruptPending), 32'h0);
    chk("rst_rvalid", 32'(OUT_csrRValid), 32'h0);
    chk("rst_medeleg", 32'(OUT_medeleg), 32'h0);
    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'hF14, 32'd5, "mhartid");
    rd(12'h7C0, 32'h0, "unknown_addr");
`ifndef CSR_TVAL_EN
    rd(12'h343, 32'h0, "mtval_absent");
`endif

    // M-trap from U
    xret(1'b1);
    chk("mret_to_u_priv", 32'(OUT_priv), 32'd0);
    trap(32'h8000_1234, 4'd2, 1'b0, 1'b0);
    chk("mtrap_priv", 32'(OUT_priv), 32'd3);
    rd(12'h341, 32'h8000_1234, "mtrap_mepc");
    rd(12'h342, 32'h2, "mtrap_mcause");
    rd(12'h300, 32'h0, "mtrap_mstatus");

    // Delegated ecall then sret
    wr(12'h100, 32'h2);
    xret(1'b1);
    trap(32'h0000_0101, 4'd8, 1'b1, 1'b0);
    chk("strap_priv", 32'(OUT_priv), 32'd1);
    rd(12'h141, 32'h100, "strap_sepc");
    rd(12'h142, 32'h8, "strap_scause");
    rd(12'h100, 32'h20, "strap_sstatus");
    xret(1'b0);
    chk("sret_priv", 32'(OUT_priv), 32'd0);
    rd(12'h100, 32'h22, "sret_sstatus");
    rd(12'h300, 32'hA2, "sret_mstatus");

    // Interrupt priority in M
    trap(32'h0, 4'd3, 1'b0, 1'b0);
    IN_irq = 3'b111;
    wr(12'h304, 32'h888);
    wr(12'h300, 32'h8);
    chk("irq_latency_pending", 32'(OUT_interruptPending), 32'd0);
    step(1);
    chk("irq_pending", 32'(OUT_interruptPending), 32'd1);
    chk("irq_cause_meip", 32'(OUT_interruptCause), 32'd11);
    chk("irq_deleg_m", 32'(OUT_interruptDelegate), 32'd0);
    IN_irq = 3'b011;
    step(1);
    chk("irq_cause_msip", 32'(OUT_interruptCause), 32'd3);
    rd(12'h344, 32'h88, "mip_hw");
    wr(12'h344, 32'hAAA);
    rd(12'h344, 32'h2AA, "mip_sw_mask");
    wr(12'h300, 32'h1000);
    rd(12'h300, 32'h0, "mpp2_as_0");
    chk("irq_mie_off", 32'(OUT_interruptPending), 32'd0);

    // Delegated interrupt: never in M, needs SIE in S
    IN_irq = 3'b000;
    wr(12'h303, 32'h20);
    wr(12'h304, 32'h20);
    step(1);
    chk("deleg_irq_in_m", 32'(OUT_interruptPending), 32'd0);
    wr(12'h300, 32'h800);
    xret(1'b1);
    chk("mret_to_s_priv", 32'(OUT_priv), 32'd1);
    step(1);
    chk("deleg_irq_s_sie0", 32'(OUT_interruptPending), 32'd0);
    wr(12'h100, 32'h2);
    step(1);
    chk("deleg_irq_pending", 32'(OUT_interruptPending), 32'd1);
    chk("deleg_irq_cause", 32'(OUT_interruptCause), 32'd5);
    chk("deleg_irq_deleg", 32'(OUT_interruptDelegate), 32'd1);

    // mret and interrupt trap in the same cycle
    trap(32'h0, 4'd0, 1'b0, 1'b0);
    wr(12'h300, 32'h80);
    IN_xretValid = 1'b1; IN_xretIsMret = 1'b1;
    trap(32'h0000_2000, 4'd7, 1'b0, 1'b1);
    IN_xretValid = 1'b0;
    chk("mret_trap_priv", 32'(OUT_priv), 32'd3);
    rd(12'h300, 32'h80, "mret_trap_mstatus");
    rd(12'h341, 32'h2000, "mret_trap_mepc");
    rd(12'h342, 32'h8000_0007, "mret_trap_mcause");
    IN_retvecSelM = 1'b1;
    #1 chk("retvec_mepc", 32'(OUT_retvec), 32'h1000);
    IN_retvecSelM = 1'b0;
    #1 chk("retvec_sepc", 32'(OUT_retvec), 32'h80);

    // Write collision with trap, then write alone with same-cycle read
    IN_csrWe = 1'b1; IN_csrAddr = 12'h305; IN_csrWData = 32'h404;
    trap(32'h3000, 4'd1, 1'b0, 1'b0);
    IN_csrWe = 1'b0;
    chk("collide_mtvec", 32'(OUT_mtvec), 32'h100);
    rd(12'h305, 32'h400, "collide_mtvec_rd");
    IN_csrWe = 1'b1; IN_csrWData = 32'h404;
    rd(12'h305, 32'h400, "no_forward_rd");
    IN_csrWe = 1'b0;
    chk("write_mtvec", 32'(OUT_mtvec), 32'h101);
    rd(12'h305, 32'h404, "write_mtvec_rd");
    wr(12'h105, 32'hFFFF_FFFF);
    chk("stvec_out", 32'(OUT_stvec), 32'h3FFF_FFFF);
    rd(12'h105, 32'hFFFF_FFFC, "stvec_mode0");
    wr(12'h302, 32'h1234_5678);
    chk("medeleg_out", 32'(OUT_medeleg), 32'h5678);
    chk("mideleg_out", 32'(OUT_mideleg), 32'h20);

    step(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_reads: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
